// File: rtl/risc_debug_pkg.sv
// Shared types for the register-trace capture block: register indexing,
// snapshot array type and the capture FSM state encoding.
package risc_debug_pkg;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned TIMER_W      = 8;

  typedef logic [4:0] reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0] regs_t [0:NUM_REGS-1];

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FROZEN = 2'd1,
    RESYNC = 2'd2
  } trace_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == '1) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/reg_trace_capture_if.sv
// Register-file write bus observed by the trace capture block.
interface reg_trace_capture_if
  import risc_debug_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            wr_en;
  reg_idx_t        wr_addr;
  logic [XLEN-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/reg_highlight_timer.sv
// Per-register highlight countdown: reloads on a published write, counts
// down once per published frame, active while nonzero.
module reg_highlight_timer
  import risc_debug_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic tick,
  output logic active
);

  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
    $error("reg_highlight_timer: HOLD_FRAMES must be within 1..255");
  end

  localparam logic [TIMER_W-1:0] HOLD = TIMER_W'(HOLD_FRAMES);

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;

  always_comb begin
    timer_next = timer;
    if (load) begin
      timer_next = HOLD;
    end else if (tick && (timer != '0)) begin
      timer_next = timer - TIMER_W'(1);
    end
  end

  // active is registered from the next count so it changes on the same edge as the timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer  <= '0;
      active <= 1'b0;
    end else begin
      timer  <= timer_next;
      active <= (timer_next != '0);
    end
  end

endmodule

// File: rtl/reg_trace_capture.sv
// Shadows core register-file writes and publishes a frame-stable snapshot
// plus per-register change highlighting to a VGA debug display.
module reg_trace_capture
  import risc_debug_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic                 clock,
  input  logic                 reset_n,
  reg_trace_capture_if.slave   wr,
  input  logic                 frame_start,
  input  logic                 freeze,
  output logic [XLEN-1:0]      regs_out [0:NUM_REGS-1],
  output logic [NUM_REGS-1:0]  changed_mask,
  output logic                 snapshot_valid,
  output logic [15:0]          write_count
);

  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
    $error("reg_trace_capture: HOLD_FRAMES must be within 1..255");
  end

  trace_state_t           state;
  logic [XLEN-1:0]        shadow [0:NUM_REGS-1];
  logic [NUM_REGS-1:1]    pending;
  logic                   accept;
  logic                   publish;

  assign accept  = wr.wr_en && (wr.wr_addr != '0);
  assign publish = frame_start && (state != FROZEN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (accept) begin
      shadow[wr.wr_addr] <= wr.wr_data;
    end
  end

  // A write landing on the publish edge survives the clear and marks the next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      if (publish) pending <= '0;
      if (accept)  pending[wr.wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_count <= '0;
    end else if (accept) begin
      write_count <= sat_inc16(write_count);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      snapshot_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_out[i] <= '0;
    end else begin
      if (publish) begin
        snapshot_valid <= 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_out[i] <= shadow[i];
      end
      case (state)
        RUN:     if (freeze) state <= FROZEN;
        FROZEN:  if (!freeze) state <= RESYNC;
        RESYNC: begin
          if (frame_start) state <= freeze ? FROZEN : RUN;
          else if (freeze) state <= FROZEN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign changed_mask[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_timer
    reg_highlight_timer #(
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (publish && pending[g]),
      .tick    (publish),
      .active  (changed_mask[g])
    );
  end

endmodule

// File: tb/tb_reg_trace_capture.sv
// Directed bench for reg_trace_capture with a queue of expected snapshot
// values checked after each publish.
module tb_reg_trace_capture;
  import risc_debug_pkg::*;

  localparam int unsigned XLEN = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              freeze = 1'b0;
  logic [XLEN-1:0]   regs_out [0:NUM_REGS-1];
  logic [31:0]       changed_mask;
  logic              snapshot_valid;
  logic [15:0]       write_count;

  int checks = 0;
  int failures = 0;

  // Kinds: 0 regs_out[idx], 1 changed_mask, 2 snapshot_valid, 3 write_count
  string       tag_q [$];
  int          kind_q [$];
  int          idx_q [$];
  logic [31:0] exp_q [$];

  reg_trace_capture_if #(.XLEN(XLEN)) bus ();

  reg_trace_capture #(
    .XLEN        (XLEN),
    .HOLD_FRAMES (3)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr             (bus),
    .frame_start    (frame_start),
    .freeze         (freeze),
    .regs_out       (regs_out),
    .changed_mask   (changed_mask),
    .snapshot_valid (snapshot_valid),
    .write_count    (write_count)
  );

  always #10 clock = ~clock;

  task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] value);
    tag_q.push_back(tag);
    kind_q.push_back(kind);
    idx_q.push_back(idx);
    exp_q.push_back(value);
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      0:       return regs_out[idx];
      1:       return changed_mask;
      2:       return {31'd0, snapshot_valid};
      default: return {16'd0, write_count};
    endcase
  endfunction

  task automatic drain();
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp_v;
    logic [31:0] obs;
    while (tag_q.size() > 0) begin
      tag   = tag_q.pop_front();
      kind  = kind_q.pop_front();
      idx   = idx_q.pop_front();
      exp_v = exp_q.pop_front();
      obs   = observe(kind, idx);
      checks++;
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge clock);
    #1;
    expect_val("rst_regs5", 0, 5, 32'h0);
    expect_val("rst_mask", 1, 0, 32'h0);
    expect_val("rst_valid", 2, 0, 32'h0);
    expect_val("rst_count", 3, 0, 32'h0);
    drain();
    @(negedge clock);
    reset_n = 1'b1;

    // Basic publish of one write
    write_reg(5'd5, 32'hDEADBEEF);
    pulse();
    expect_val("x5_data", 0, 5, 32'hDEADBEEF);
    expect_val("x5_mask", 1, 0, 32'h0000_0020);
    expect_val("x5_valid", 2, 0, 32'h1);
    expect_val("x5_count", 3, 0, 32'd1);
    drain();

    // Writes to x0 are ignored
    write_reg(5'd0, 32'h12345678);
    pulse();
    expect_val("x0_data", 0, 0, 32'h0);
    expect_val("x0_mask", 1, 0, 32'h0000_0020);
    expect_val("x0_count", 3, 0, 32'd1);
    drain();

    // Highlight lasts HOLD_FRAMES=3 publishes
    write_reg(5'd7, 32'h7);
    pulse(); expect_val("hold_p1", 1, 0, 32'h0000_00A0); drain();
    pulse(); expect_val("hold_p2", 1, 0, 32'h0000_0080); drain();
    pulse(); expect_val("hold_p3", 1, 0, 32'h0000_0080); drain();
    pulse(); expect_val("hold_p4", 1, 0, 32'h0000_0000); drain();

    // Write coincident with frame_start lands in the following frame
    @(negedge clock);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h1; frame_start = 1'b1;
    @(negedge clock);
    bus.wr_en = 1'b0; frame_start = 1'b0;
    expect_val("coinc_data0", 0, 9, 32'h0);
    expect_val("coinc_mask0", 1, 0, 32'h0);
    expect_val("coinc_count", 3, 0, 32'd3);
    drain();
    pulse();
    expect_val("coinc_data1", 0, 9, 32'h1);
    expect_val("coinc_mask1", 1, 0, 32'h0000_0200);
    drain();

    // Freeze holds the snapshot, then resync publishes
    @(negedge clock); freeze = 1'b1;
    write_reg(5'd3, 32'hAA);
    pulse(); pulse();
    expect_val("frz_data", 0, 3, 32'h0);
    expect_val("frz_mask", 1, 0, 32'h0000_0200);
    expect_val("frz_count", 3, 0, 32'd4);
    drain();
    @(negedge clock); freeze = 1'b0;
    pulse();
    expect_val("resync_data", 0, 3, 32'hAA);
    expect_val("resync_mask", 1, 0, 32'h0000_0208);
    drain();

    // freeze rising with frame_start publishes that frame first
    write_reg(5'd4, 32'h44);
    @(negedge clock); freeze = 1'b1; frame_start = 1'b1;
    @(negedge clock); frame_start = 1'b0;
    expect_val("frzpub_data", 0, 4, 32'h44);
    expect_val("frzpub_mask", 1, 0, 32'h0000_0218);
    drain();
    write_reg(5'd4, 32'h55);
    pulse();
    expect_val("frzhold_data", 0, 4, 32'h44);
    expect_val("frzhold_mask", 1, 0, 32'h0000_0218);
    drain();
    @(negedge clock); freeze = 1'b0;
    pulse();
    expect_val("frzrel_data", 0, 4, 32'h55);
    expect_val("frzrel_mask", 1, 0, 32'h0000_0018);
    expect_val("frzrel_count", 3, 0, 32'd6);
    drain();

    // Saturating write counter
    @(negedge clock);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'hCAFE;
    repeat (70000) @(negedge clock);
    bus.wr_en = 1'b0;
    expect_val("sat_count", 3, 0, 32'h0000_FFFF);
    drain();

    // Asynchronous reset mid-frame clears outputs immediately
    write_reg(5'd10, 32'h1234);
    #3 reset_n = 1'b0;
    #1;
    expect_val("arst_regs4", 0, 4, 32'h0);
    expect_val("arst_regs3", 0, 3, 32'h0);
    expect_val("arst_mask", 1, 0, 32'h0);
    expect_val("arst_valid", 2, 0, 32'h0);
    expect_val("arst_count", 3, 0, 32'h0);
    drain();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    write_reg(5'd2, 32'h22);
    pulse();
    expect_val("post_regs1", 0, 1, 32'h0);
    expect_val("post_regs10", 0, 10, 32'h0);
    expect_val("post_regs2", 0, 2, 32'h22);
    expect_val("post_mask", 1, 0, 32'h0000_0004);
    expect_val("post_valid", 2, 0, 32'h1);
    expect_val("post_count", 3, 0, 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
